tone_gen: RTL and testbench
===========================

TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 The block SHALL have parameter BIT_WIDTH, default 16, meaning signed sample width; the frequency input is BIT_WIDTH+1 bits.
REQ-002 The block SHALL have parameter FS, default 48000, meaning output sample rate in Hz.
REQ-003 The block SHALL have parameter CLK_DIV, default 500, meaning clk cycles per sample (clk = FS*CLK_DIV).
REQ-004 The block SHALL have parameter PHASE_W, default 24, meaning phase accumulator width.
REQ-005 The block SHALL have parameter LUT_BITS, default 8, meaning quarter-wave table address width.
REQ-006 The block SHALL have port clk, input, 1, meaning the single clock; one clock, all logic on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-008 The block SHALL have port freq_valid, input, 1, meaning a new tone request is present on freq.
REQ-009 The block SHALL have port freq, input, BIT_WIDTH+1, meaning requested tone in Hz, unsigned.
REQ-010 The block SHALL have port freq_ready, output, 1, meaning a request can be accepted this cycle.
REQ-011 The block SHALL have port sample, output, BIT_WIDTH, meaning two's-complement sine sample.
REQ-012 The block SHALL have port sample_valid, output, 1, meaning a one-cycle strobe for a new sample.
REQ-013 The block SHALL have port freq_err, output, 1, meaning a one-cycle strobe for a rejected out-of-range request.

Function
REQ-014 The block SHALL use states IDLE (silent), CALC (computing increment), RUN (tone playing).
REQ-015 The block SHALL drive freq_ready high in IDLE and RUN and low in CALC; a request is accepted when freq_valid && freq_ready.
REQ-016 On acceptance with 0 < freq < FS/2, the block SHALL capture freq and enter CALC.
REQ-017 In CALC, the block SHALL compute inc = floor(freq * 2^PHASE_W / FS) serially; CALC SHALL last exactly BIT_WIDTH+1+PHASE_W cycles (41 at defaults), then enter RUN with inc loaded.
REQ-018 On acceptance with freq == 0, the block SHALL enter IDLE next cycle and set inc to 0.
REQ-019 On acceptance with freq >= FS/2, the block SHALL pulse freq_err next cycle and leave state and inc unchanged.
REQ-020 The tick counter SHALL count 0..CLK_DIV-1 continuously from reset regardless of state; the tick SHALL be the cycle where it equals CLK_DIV-1.
REQ-021 On each tick in RUN, the block SHALL set phase to phase + inc, mod 2^PHASE_W.
REQ-022 During CALC after a retune from RUN, ticks SHALL keep using the old inc (tone continues); a CALC completion coinciding with a tick SHALL apply the new inc from the next tick.
REQ-023 On entering RUN from IDLE, phase SHALL be 0; a retune from RUN SHALL keep phase unchanged (phase-continuous).
REQ-024 The sample SHALL be derived from the updated phase: q = top 2 bits, idx = next LUT_BITS bits.
REQ-025 The sample SHALL be lut[idx] for q=0, lut[~idx] for q=1, -lut[idx] for q=2, and -lut[~idx] for q=3.
REQ-026 Each lut[i] SHALL equal round((2^(BIT_WIDTH-1)-1)*sin(pi/2*(i+0.5)/2^LUT_BITS)); at defaults lut[0]=101 and lut[255]=32767.
REQ-027 sample_valid SHALL pulse exactly 2 cycles after every tick, in all states; sample SHALL hold between pulses.
REQ-028 sample SHALL be 0 at every strobe while in IDLE.

Reset
REQ-029 While reset is low, the block SHALL hold state=IDLE, phase=0, inc=0, tick counter=0, sample=0, sample_valid=0, freq_err=0, freq_ready=1.
REQ-030 An assertion of reset during CALC or RUN SHALL abort the divide with no stale increment surviving.

Structure
REQ-031 Package tone_pkg SHALL hold the state enum and default FS/CLK_DIV/PHASE_W/LUT_BITS constants.
REQ-032 The serial restoring divider SHALL be sub-module tone_div with ports start, dividend, done, and quotient.
REQ-033 The LUT SHALL be a registered ROM inside tone_gen.

Verification
REQ-034 Reset, no requests -> sample_valid every 500 cycles, first at cycle 501 after release; sample=0 throughout.
REQ-035 freq=12000 accepted -> freq_ready low 41 cycles; inc=0x400000; samples 32767, -101, -32767, 101 repeating.
REQ-036 RUN at 12000, then freq=6000 -> no gap in sample_valid; phase continuous; new inc=0x200000 after CALC.
REQ-037 freq=24000 -> freq_err one-cycle pulse; state/inc unchanged; freq=0 -> IDLE, samples 0.
REQ-038 freq_valid held during CALC -> ignored until freq_ready rises; CALC-done on tick cycle -> old inc used for that tick.
REQ-039 Reset asserted mid-CALC and mid-RUN -> all outputs at reset values asynchronously; clean restart afterward.

Source files
------------

// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tone_pkg
// Description : Shared types and constants for the tone generator: the
//               controller state encoding, default timing/phase constants,
//               and the constant function that builds quarter-wave sine
//               table entries at elaboration time.
// Revision    : 1.0 - initial release
// ============================================================================
package tone_pkg;

    localparam int c_bit_width_default = 16;
    localparam int c_fs_default        = 48000;
    localparam int c_clk_div_default   = 500;
    localparam int c_phase_w_default   = 24;
    localparam int c_lut_bits_default  = 8;

    localparam real c_half_pi = 1.5707963267948966;

    // IDLE: silent, CALC: serial divide in progress, RUN: tone playing
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } state_t;

    // Quarter-wave entry i = round(amp * sin(pi/2 * (i + 0.5) / 2^lut_bits)).
    // Sine is evaluated with a Taylor series; over [0, pi/2] the series
    // truncation error is far below the rounding step, so every entry
    // matches the exact rounded value.  Only used in constant context.
    function automatic int lut_entry(input int idx, input int bit_width,
                                     input int lut_bits);
        real x;
        real term;
        real sum;
        real amp;
        x    = c_half_pi * (real'(idx) + 0.5) / real'(2 ** lut_bits);
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        amp = real'((2 ** (bit_width - 1)) - 1);
        return $rtoi(amp * sum + 0.5);
    endfunction

endpackage : tone_pkg
`default_nettype wire

// File: rtl/tone_div.sv
`default_nettype none
// ============================================================================
// Module      : tone_div
// Description : Serial restoring divider by a constant divisor.  One quotient
//               bit is produced per clock, MSB first; a divide takes exactly
//               DVD_W cycles after the start cycle.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset, aborts any divide
//   start    : load dividend and begin a divide (one cycle)
//   dividend : DVD_W-bit unsigned dividend, sampled when start is high
//   done     : high during the final iteration cycle of a divide
//   quotient : low QUO_W bits of the finished quotient, valid while done
// Revision    : 1.0 - initial release
// ============================================================================
module tone_div #(
    parameter int DVD_W   = 41,
    parameter int DIVISOR = 48000,
    parameter int QUO_W   = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    output logic             done,
    output logic [QUO_W-1:0] quotient
);

    localparam int c_rem_w = $clog2(DIVISOR) + 1;
    localparam int c_cnt_w = $clog2(DVD_W + 1);
    localparam logic [c_rem_w-1:0] c_divisor = c_rem_w'(DIVISOR);
    localparam logic [c_cnt_w-1:0] c_steps   = c_cnt_w'(DVD_W);

    // Remainder is always below the divisor, so one bit less than the trial
    // value is enough to hold it.
    logic [c_rem_w-2:0] r_rem;
    logic [DVD_W-1:0]   r_dvd;   // dividend bits shift out, quotient bits shift in
    logic [c_cnt_w-1:0] r_cnt;

    logic [c_rem_w-1:0] w_trial;
    logic               w_qbit;
    logic [c_rem_w-2:0] w_rem_next;
    logic [DVD_W-1:0]   w_dvd_next;

    always_comb begin
        w_trial    = {r_rem, r_dvd[DVD_W-1]};
        w_qbit     = (w_trial >= c_divisor);
        w_rem_next = w_qbit ? (c_rem_w-1)'(w_trial - c_divisor)
                            : w_trial[c_rem_w-2:0];
        w_dvd_next = {r_dvd[DVD_W-2:0], w_qbit};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem <= '0;
            r_dvd <= '0;
            r_cnt <= '0;
        end else if (start) begin
            r_rem <= '0;
            r_dvd <= dividend;
            r_cnt <= c_steps;
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_next;
            r_dvd <= w_dvd_next;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Final quotient is presented during the last iteration so the caller
    // can load it on the same edge that retires the divide.
    assign done     = (r_cnt == c_cnt_w'(1));
    assign quotient = w_dvd_next[QUO_W-1:0];

endmodule : tone_div
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tone_gen
// Description : Direct digital synthesis sine tone generator.  A requested
//               frequency is converted to a phase increment by a serial
//               divider; a phase accumulator advances once per sample tick
//               and drives a quarter-wave sine ROM.
//   clk          : clock, rising edge (FS * CLK_DIV Hz)
//   reset        : asynchronous active-low reset
//   freq_valid   : tone request present on freq
//   freq         : requested tone in Hz, unsigned, BIT_WIDTH+1 bits
//   freq_ready   : request can be accepted this cycle (low while computing)
//   sample       : two's-complement sine sample, held between strobes
//   sample_valid : one-cycle strobe, two cycles after each sample tick
//   freq_err     : one-cycle strobe after an out-of-range request
// Revision    : 1.0 - initial release
// ============================================================================
module tone_gen
    import tone_pkg::*;
#(
    parameter int BIT_WIDTH = c_bit_width_default,
    parameter int FS        = c_fs_default,
    parameter int CLK_DIV   = c_clk_div_default,
    parameter int PHASE_W   = c_phase_w_default,
    parameter int LUT_BITS  = c_lut_bits_default
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        freq_valid,
    input  logic [BIT_WIDTH:0]          freq,
    output logic                        freq_ready,
    output logic signed [BIT_WIDTH-1:0] sample,
    output logic                        sample_valid,
    output logic                        freq_err
);

    localparam int c_dvd_w     = BIT_WIDTH + 1 + PHASE_W;
    localparam int c_lut_depth = 2 ** LUT_BITS;
    localparam int c_tick_w    = $clog2(CLK_DIV);
    localparam logic [c_tick_w-1:0]  c_tick_last = c_tick_w'(CLK_DIV - 1);
    localparam logic [BIT_WIDTH:0]   c_half_fs   = (BIT_WIDTH + 1)'(FS / 2);

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_ready;

    logic [c_tick_w-1:0]   r_tick_cnt;
    logic                  w_tick;
    logic [PHASE_W-1:0]    r_phase;
    logic [PHASE_W-1:0]    r_inc;
    logic                  r_active;     // phase advances on ticks (RUN, or CALC retuning from RUN)
    logic [PHASE_W-1:0]    w_phase_upd;
    logic [1:0]            w_quad;
    logic [LUT_BITS-1:0]   w_idx;

    logic                  w_accept;
    logic                  w_acc_zero;
    logic                  w_acc_err;
    logic                  w_acc_calc;
    logic                  w_div_done;
    logic                  w_calc_done;
    logic [PHASE_W-1:0]    w_quotient;

    logic [BIT_WIDTH-2:0]  w_rom [c_lut_depth];
    logic [BIT_WIDTH-2:0]  r_lut;
    logic                  r_neg;
    logic                  r_mute;
    logic                  r_tick_d;
    logic [BIT_WIDTH-1:0]  w_mag;
    logic [BIT_WIDTH-1:0]  r_sample;
    logic                  r_sample_valid;
    logic                  r_freq_err;

    // ------------------------------------------------------------------
    // Quarter-wave sine table, built from constants at elaboration
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < c_lut_depth; gi++) begin : g_rom
        localparam int c_val = lut_entry(gi, BIT_WIDTH, LUT_BITS);
        assign w_rom[gi] = (BIT_WIDTH-1)'(c_val);
    end

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept   = freq_valid && w_ready;
        w_acc_zero = w_accept && (freq == '0);
        w_acc_err  = w_accept && (freq >= c_half_fs);
        w_acc_calc = w_accept && !w_acc_zero && !w_acc_err;
    end

    tone_div #(
        .DVD_W   (c_dvd_w),
        .DIVISOR (FS),
        .QUO_W   (PHASE_W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (w_acc_calc),
        .dividend ({freq, {PHASE_W{1'b0}}}),
        .done     (w_div_done),
        .quotient (w_quotient)
    );

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b1;
        case (r_state)
            IDLE, RUN: begin
                if (w_acc_zero)      w_state_next = IDLE;
                else if (w_acc_calc) w_state_next = CALC;
            end
            CALC: begin
                w_ready = 1'b0;
                if (w_div_done) w_state_next = RUN;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_calc_done = (r_state == CALC) && w_div_done;
    assign freq_ready  = w_ready;

    // ------------------------------------------------------------------
    // Tick counter, phase accumulator and sample pipeline
    // ------------------------------------------------------------------
    assign w_tick      = (r_tick_cnt == c_tick_last);
    assign w_phase_upd = r_phase + r_inc;
    assign w_quad      = w_phase_upd[PHASE_W-1 -: 2];
    assign w_idx       = w_phase_upd[PHASE_W-3 -: LUT_BITS];
    assign w_mag       = {1'b0, r_lut};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt     <= '0;
            r_phase        <= '0;
            r_inc          <= '0;
            r_active       <= 1'b0;
            r_lut          <= '0;
            r_neg          <= 1'b0;
            r_mute         <= 1'b1;
            r_tick_d       <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_freq_err     <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
            r_freq_err <= w_acc_err;

            // A tick that coincides with CALC completion still uses the
            // old increment; the new one takes effect from the next tick.
            if (w_acc_zero) begin
                r_inc    <= '0;
                r_active <= 1'b0;
            end else if (w_calc_done) begin
                r_inc    <= w_quotient;
                r_active <= 1'b1;
            end

            // Starting from silence begins at phase 0; retuning keeps phase.
            if (w_acc_zero)
                r_phase <= '0;
            else if (w_tick && r_active)
                r_phase <= w_phase_upd;
            else if (w_calc_done && !r_active)
                r_phase <= '0;

            // Stage 1: registered ROM read addressed by the updated phase.
            // Odd quadrants read the table backwards.
            r_tick_d <= w_tick;
            if (w_tick) begin
                r_lut  <= w_rom[w_quad[0] ? ~w_idx : w_idx];
                r_neg  <= w_quad[1];
                r_mute <= !r_active || w_acc_zero;
            end

            // Stage 2: apply sign (lower half-wave) or silence.
            r_sample_valid <= r_tick_d;
            if (r_tick_d) begin
                if (r_mute)     r_sample <= '0;
                else if (r_neg) r_sample <= -w_mag;
                else            r_sample <= w_mag;
            end
        end
    end

    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign freq_err     = r_freq_err;

endmodule : tone_gen
`default_nettype wire

// File: tb/tb_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_tone_gen
// Description : Directed self-checking bench for tone_gen at default
//               parameters (48 kHz, 500 clocks per sample, 24-bit phase).
//               Expected samples come from a hand-computed table indexed by
//               phase in eighths of a turn.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tone_gen;

    logic               clk = 1'b0;
    logic               reset;
    logic               freq_valid;
    logic [16:0]        freq;
    logic               freq_ready;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               freq_err;

    int n_checks = 0;
    int n_pass   = 0;
    int k_phase  = 0;   // expected phase in units of 0x200000 (1/8 turn)

    // Sample at phase k*0x200000: quadrant = k/2, table index 0 or 128
    logic signed [15:0] c_tab [8] = '{16'sd101, 16'sd23241, 16'sd32767, 16'sd23099,
                                      -16'sd101, -16'sd23241, -16'sd32767, -16'sd23099};

    tone_gen dut (
        .clk          (clk),
        .reset        (reset),
        .freq_valid   (freq_valid),
        .freq         (freq),
        .freq_ready   (freq_ready),
        .sample       (sample),
        .sample_valid (sample_valid),
        .freq_err     (freq_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the next sample strobe; reports cycles waited.
    task automatic wait_sv(output int steps, output bit got);
        steps = 0;
        got   = 1'b0;
        while (!got && steps < 1000) begin
            step();
            steps++;
            if (sample_valid === 1'b1) got = 1'b1;
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        freq_valid = 1'b0;
        freq       = '0;
        #2;
        n_checks++;
        if (sample !== 16'sd0 || sample_valid !== 1'b0 || freq_err !== 1'b0 || freq_ready !== 1'b1)
            $display("FAIL reset_outputs: sample=%0d sv=%0b err=%0b ready=%0b, required 0/0/0/1",
                     sample, sample_valid, freq_err, freq_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        release_reset();
    endtask

    task automatic test_idle();
        int n; bit got;
        wait_sv(n, got);
        n_checks++;
        if (!got || n != 501 || sample !== 16'sd0)
            $display("FAIL idle_first: got=%0b cycle=%0d sample=%0d, required cycle=501 sample=0", got, n, sample);
        else n_pass++;
        wait_sv(n, got);
        n_checks++;
        if (!got || n != 500 || sample !== 16'sd0)
            $display("FAIL idle_period: got=%0b gap=%0d sample=%0d, required gap=500 sample=0", got, n, sample);
        else n_pass++;
    endtask

    task automatic test_tone_12k();
        int n; bit got; int low;
        logic signed [15:0] held;
        freq_valid = 1'b1;
        freq       = 17'd12000;
        step();
        freq_valid = 1'b0;
        low = 0;
        while (freq_ready === 1'b0 && low < 100) begin
            low++;
            step();
        end
        n_checks++;
        if (low != 41)
            $display("FAIL calc_ready_low: cycles=%0d, required 41", low);
        else n_pass++;
        k_phase = 0;
        for (int i = 0; i < 4; i++) begin
            wait_sv(n, got);
            k_phase = (k_phase + 2) % 8;
            n_checks++;
            if (!got || n != ((i == 0) ? 458 : (i == 1) ? 499 : 500) || sample !== c_tab[k_phase])
                $display("FAIL run12k[%0d]: got=%0b gap=%0d sample=%0d, required sample=%0d",
                         i, got, n, sample, c_tab[k_phase]);
            else n_pass++;
            if (i == 0) begin
                held = sample;
                step();
                n_checks++;
                if (sample !== held || sample_valid !== 1'b0)
                    $display("FAIL sample_hold: sample=%0d sv=%0b, required sample=%0d sv=0",
                             sample, sample_valid, held);
                else n_pass++;
            end
        end
    endtask

    // Retune so the final CALC cycle lands on the tick: that tick still
    // advances by the old increment, later ticks by the new one.
    task automatic test_retune_on_tick();
        int n; bit got;
        repeat (457) step();
        freq_valid = 1'b1;
        freq       = 17'd6000;
        step();
        freq_valid = 1'b0;
        n_checks++;
        if (freq_ready !== 1'b0)
            $display("FAIL retune_calc: ready=%0b, required 0", freq_ready);
        else n_pass++;
        wait_sv(n, got);
        k_phase = (k_phase + 2) % 8;
        n_checks++;
        if (!got || n != 42 || sample !== c_tab[k_phase] || freq_ready !== 1'b1)
            $display("FAIL retune_tick: got=%0b gap=%0d sample=%0d ready=%0b, required gap=42 sample=%0d ready=1",
                     got, n, sample, freq_ready, c_tab[k_phase]);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            wait_sv(n, got);
            k_phase = (k_phase + 1) % 8;
            n_checks++;
            if (!got || n != 500 || sample !== c_tab[k_phase])
                $display("FAIL run6k[%0d]: got=%0b gap=%0d sample=%0d, required gap=500 sample=%0d",
                         i, got, n, sample, c_tab[k_phase]);
            else n_pass++;
        end
    endtask

    task automatic test_err();
        int n; bit got;
        freq_valid = 1'b1;
        freq       = 17'd24000;
        step();
        freq_valid = 1'b0;
        n_checks++;
        if (freq_err !== 1'b1 || freq_ready !== 1'b1)
            $display("FAIL err_pulse: err=%0b ready=%0b, required 1/1", freq_err, freq_ready);
        else n_pass++;
        step();
        n_checks++;
        if (freq_err !== 1'b0)
            $display("FAIL err_width: err=%0b, required 0", freq_err);
        else n_pass++;
        wait_sv(n, got);
        k_phase = (k_phase + 1) % 8;
        n_checks++;
        if (!got || n != 498 || sample !== c_tab[k_phase])
            $display("FAIL err_keeps_inc: got=%0b gap=%0d sample=%0d, required gap=498 sample=%0d",
                     got, n, sample, c_tab[k_phase]);
        else n_pass++;
    endtask

    task automatic test_zero();
        int n; bit got;
        freq_valid = 1'b1;
        freq       = 17'd0;
        step();
        freq_valid = 1'b0;
        n_checks++;
        if (freq_ready !== 1'b1 || freq_err !== 1'b0)
            $display("FAIL zero_accept: ready=%0b err=%0b, required 1/0", freq_ready, freq_err);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            wait_sv(n, got);
            n_checks++;
            if (!got || n != ((i == 0) ? 499 : 500) || sample !== 16'sd0)
                $display("FAIL zero_silent[%0d]: got=%0b gap=%0d sample=%0d, required sample=0", i, got, n, sample);
            else n_pass++;
        end
    endtask

    // Request held valid (with a changing, out-of-range value) through CALC
    // must not restart the divide or raise freq_err.
    task automatic test_hold_valid();
        int n; bit got; int low; int errs;
        freq_valid = 1'b1;
        freq       = 17'd12000;
        step();
        freq = 17'd24000;
        low  = 0;
        errs = 0;
        while (freq_ready === 1'b0 && low < 100) begin
            low++;
            if (freq_err === 1'b1) errs++;
            step();
        end
        freq_valid = 1'b0;
        freq       = 17'd0;
        n_checks++;
        if (low != 41 || errs != 0)
            $display("FAIL hold_valid: low=%0d errs=%0d, required 41/0", low, errs);
        else n_pass++;
        wait_sv(n, got);
        k_phase = 2;
        n_checks++;
        if (!got || n != 458 || sample !== c_tab[k_phase])
            $display("FAIL start_from_idle: got=%0b gap=%0d sample=%0d, required gap=458 sample=%0d",
                     got, n, sample, c_tab[k_phase]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int n; bit got;
        step();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (sample !== 16'sd0 || sample_valid !== 1'b0 || freq_ready !== 1'b1 || freq_err !== 1'b0)
            $display("FAIL reset_run_async: sample=%0d sv=%0b ready=%0b err=%0b, required 0/0/1/0",
                     sample, sample_valid, freq_ready, freq_err);
        else n_pass++;
        release_reset();
        wait_sv(n, got);
        n_checks++;
        if (!got || n != 501 || sample !== 16'sd0)
            $display("FAIL reset_run_restart: got=%0b cycle=%0d sample=%0d, required cycle=501 sample=0",
                     got, n, sample);
        else n_pass++;
    endtask

    task automatic test_reset_mid_calc();
        int n; bit got;
        freq_valid = 1'b1;
        freq       = 17'd6000;
        step();
        freq_valid = 1'b0;
        repeat (10) step();
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if (freq_ready !== 1'b1 || sample !== 16'sd0 || sample_valid !== 1'b0)
            $display("FAIL reset_calc_async: ready=%0b sample=%0d sv=%0b, required 1/0/0",
                     freq_ready, sample, sample_valid);
        else n_pass++;
        release_reset();
        wait_sv(n, got);
        n_checks++;
        if (!got || n != 501 || sample !== 16'sd0)
            $display("FAIL reset_calc_idle: got=%0b cycle=%0d sample=%0d, required cycle=501 sample=0",
                     got, n, sample);
        else n_pass++;
        freq_valid = 1'b1;
        freq       = 17'd12000;
        step();
        freq_valid = 1'b0;
        k_phase = 0;
        for (int i = 0; i < 2; i++) begin
            wait_sv(n, got);
            k_phase = (k_phase + 2) % 8;
            n_checks++;
            if (!got || n != ((i == 0) ? 499 : 500) || sample !== c_tab[k_phase])
                $display("FAIL clean_restart[%0d]: got=%0b gap=%0d sample=%0d, required sample=%0d",
                         i, got, n, sample, c_tab[k_phase]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_tone_12k();
        test_retune_on_tick();
        test_err();
        test_zero();
        test_hold_valid();
        test_reset_mid_run();
        test_reset_mid_calc();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tone_gen
`default_nettype wire
